store_merge_unit: RTL and testbench

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

---
 rtl/store_merge_unit.sv | 114 +++++++++++
 tb/tb_store_merge_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Sub-word store merger: read the containing word, splice in the store bytes, write the whole word back.
// Define STORE_ALIGN_CHECK_EN to reject stores whose byte offset is not a multiple of their size.
module store_merge_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [2:0]        req_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RSP} state_t;
  state_t state, state_nxt;

  logic [3:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [DATA_W-1:0] data_q;

  logic              accept;
  logic [3:0]        req_size;
  logic [OFF_W-1:0]  req_off;
  logic              req_bad;
  logic              req_full;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] merged;

  function automatic logic [3:0] size_of(input logic [2:0] t);
    case (t)
      3'd1:    size_of = 4'd8;
      3'd2:    size_of = 4'd4;
      3'd3:    size_of = 4'd2;
      3'd4:    size_of = 4'd1;
      default: size_of = 4'd0;
    endcase
  endfunction

  // Request classification is done on the live inputs so the IDLE exit can branch immediately.
  always_comb begin
    req_size = size_of(req_type);
    req_off  = req_addr[OFF_W-1:0];
    req_bad  = (req_size == 4'd0) || (32'(req_size) > NB);
`ifdef STORE_ALIGN_CHECK_EN
    if ((req_off & OFF_W'(req_size - 4'd1)) != '0) req_bad = 1'b1;
`endif
    req_full = !req_bad && (32'(req_size) == NB) && (req_off == '0);
  end

  assign accept = req_valid && req_ready;

  // Bytes shifted past the top lane fall off the word, which is how misaligned stores are clipped.
  always_comb begin
    lane_mask = ~({DATA_W{1'b1}} << {size_q, 3'b000}) << {off_q, 3'b000};
    merged    = (mem_rdata & ~lane_mask) | ((data_q << {off_q, 3'b000}) & lane_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_bad ? RSP : (req_full ? WR : RD);
      RD:      state_nxt = MRG;
      MRG:     state_nxt = WR;
      WR:      state_nxt = RSP;
      RSP:     if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_rd_en  = (state == RD);
    mem_wr_en  = (state == WR);
    resp_valid = (state == RSP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q    <= '0;
      off_q     <= '0;
      data_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      resp_err  <= 1'b0;
    end else if (accept) begin
      size_q    <= req_size;
      off_q     <= req_off;
      data_q    <= req_data;
      mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      mem_wdata <= req_data;
      resp_err  <= req_bad;
    end else if (state == MRG) begin
      mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: behavioural word memory, scoreboard of expected responses,
// directed store vectors, randomized stores with random response backpressure, and reset abort in merge.
module tb_store_merge_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [2:0]  req_type;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rdata = '0;
  logic        mem_wr_en;
  logic [63:0] mem_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;

  store_merge_unit #(.DATA_W(64), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_type(req_type),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] wdata;
    int          lat;
    int          rd_n;
    int          wr_n;
    logic [31:0] addr;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Word memory with one-cycle read latency.
  logic [63:0] mem [logic [31:0]];

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_rd(mem_addr);
    if (mem_wr_en) mem[mem_addr] = mem_wdata;
  end

  function automatic exp_t mk(input logic err, input logic [63:0] wd, input int lat,
                              input int rd_n, input int wr_n, input logic [31:0] a);
    exp_t e;
    e.err = err; e.wdata = wd; e.lat = lat; e.rd_n = rd_n; e.wr_n = wr_n; e.addr = a;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [63:0] d, input logic [2:0] t);
    exp_t        e;
    int          sz;
    int          off;
    logic [63:0] old;
    logic [7:0]  b [8];
    case (t)
      3'd1:    sz = 8;
      3'd2:    sz = 4;
      3'd3:    sz = 2;
      3'd4:    sz = 1;
      default: sz = 0;
    endcase
    off    = int'(a[2:0]);
    e.addr = {a[31:3], 3'b000};
    e.err  = (sz == 0);
`ifdef STORE_ALIGN_CHECK_EN
    if (sz != 0 && (off % sz) != 0) e.err = 1'b1;
`endif
    old = mem_rd(e.addr);
    for (int k = 0; k < 8; k++) begin
      if (k >= off && k < off + sz) b[k] = 8'(d >> (8 * (k - off)));
      else                          b[k] = 8'(old >> (8 * k));
    end
    e.wdata = '0;
    for (int k = 0; k < 8; k++) e.wdata = e.wdata | (64'(b[k]) << (8 * k));
    if (e.err) begin
      e.lat = 1; e.rd_n = 0; e.wr_n = 0;
    end else if (sz == 8 && off == 0) begin
      e.lat = 2; e.rd_n = 0; e.wr_n = 1; e.wdata = d;
    end else begin
      e.lat = 4; e.rd_n = 1; e.wr_n = 1;
    end
    return e;
  endfunction

  // Monitor: samples on the falling edge, tracks per-store strobes, pops the scoreboard on handshake.
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          lat = 0;
  int          total_wr = 0;
  logic        rsp_seen = 1'b0;
  logic [63:0] wr_dat = '0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_rd_en && mem_wr_en) chk("rd_wr_overlap", 64'd1, 64'd0);
      if (resp_valid) chk("ready_in_rsp", 64'(req_ready), 64'd0);
      if (mem_rd_en) begin
        rd_cnt++;
        if (sbq.size() > 0) chk("rd_addr", 64'(mem_addr), 64'(sbq[0].addr));
      end
      if (mem_wr_en) begin
        wr_cnt++;
        total_wr++;
        wr_dat = mem_wdata;
        if (sbq.size() > 0) chk("wr_addr", 64'(mem_addr), 64'(sbq[0].addr));
      end
      if (resp_valid && !rsp_seen) begin
        rsp_seen = 1'b1;
        lat = cyc - acc_cyc;
      end
      if (resp_valid && resp_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_err", 64'(resp_err), 64'(mon_e.err));
          chk("latency", 64'(lat), 64'(mon_e.lat));
          chk("rd_count", 64'(rd_cnt), 64'(mon_e.rd_n));
          chk("wr_count", 64'(wr_cnt), 64'(mon_e.wr_n));
          if (mon_e.wr_n > 0) chk("wdata", wr_dat, mon_e.wdata);
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc  = cyc;
        rd_cnt   = 0;
        wr_cnt   = 0;
        rsp_seen = 1'b0;
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [63:0] d, input logic [2:0] t,
                          input exp_t e, input int hold, input logic rnd);
    int n;
    sbq.push_back(e);
    req_addr  = a;
    req_data  = d;
    req_type  = t;
    req_valid = 1'b1;
    if (hold > 0) resp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      sbq.delete();
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request bus after acceptance; the unit must have registered everything it needs.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = {$urandom, $urandom};
    req_type  = 3'($urandom_range(0, 7));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 64'(resp_valid), 64'd1);
        chk("hold_err", 64'(resp_err), 64'(e.err));
        chk("hold_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
    end
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      if (rnd) resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    resp_ready = 1'b1;
    if (sbq.size() != 0) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [63:0] rdat;
    logic [2:0]  rt;
    int          tw;

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_type   = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;

    mem[32'h1000] = 64'h1122334455667788;
    do_store(32'h1003, 64'h00000000000000AB, 3'd4, mk(1'b0, 64'h11223344AB667788, 4, 1, 1, 32'h1000), 0, 1'b0);
    chk("mem_after_sb", mem_rd(32'h1000), 64'h11223344AB667788);
    mem[32'h1000] = 64'h1122334455667788;
    do_store(32'h1002, 64'h000000000000BEEF, 3'd3, mk(1'b0, 64'h11223344BEEF7788, 4, 1, 1, 32'h1000), 0, 1'b0);
    do_store(32'h2000, 64'hCAFEBABE00000001, 3'd1, mk(1'b0, 64'hCAFEBABE00000001, 2, 0, 1, 32'h2000), 0, 1'b0);
    chk("mem_after_sd", mem_rd(32'h2000), 64'hCAFEBABE00000001);
    do_store(32'h2008, 64'h0000000000000055, 3'd0, mk(1'b1, 64'd0, 1, 0, 0, 32'h2008), 5, 1'b0);
    mem[32'h1000] = 64'h1122334455667788;
`ifdef STORE_ALIGN_CHECK_EN
    do_store(32'h1006, 64'h00000000DEADBEEF, 3'd2, mk(1'b1, 64'd0, 1, 0, 0, 32'h1000), 0, 1'b0);
    chk("mem_misaligned_sw", mem_rd(32'h1000), 64'h1122334455667788);
`else
    do_store(32'h1006, 64'h00000000DEADBEEF, 3'd2, mk(1'b0, 64'hBEEF334455667788, 4, 1, 1, 32'h1000), 0, 1'b0);
    chk("mem_misaligned_sw", mem_rd(32'h1000), 64'hBEEF334455667788);
`endif
    do_store(32'h2010, 64'h1234, 3'd7, mk(1'b1, 64'd0, 1, 0, 0, 32'h2010), 0, 1'b0);
    do_store(32'h2004, 64'h000000000BADF00D, 3'd2, mk(1'b0, 64'h0BADF00D00000001, 4, 1, 1, 32'h2000), 0, 1'b0);
`ifdef STORE_ALIGN_CHECK_EN
    do_store(32'h2001, 64'h8877665544332211, 3'd1, mk(1'b1, 64'd0, 1, 0, 0, 32'h2000), 0, 1'b0);
`else
    do_store(32'h2001, 64'h8877665544332211, 3'd1, mk(1'b0, 64'h7766554433221101, 4, 1, 1, 32'h2000), 0, 1'b0);
`endif

    for (int w = 0; w < 8; w++) mem[32'h3000 + 32'(8 * w)] = {$urandom, $urandom};
    for (int i = 0; i < 40; i++) begin
      ra   = 32'h3000 + 32'($urandom_range(0, 63));
      rdat = {$urandom, $urandom};
      rt   = 3'($urandom_range(0, 5));
      do_store(ra, rdat, rt, model(ra, rdat, rt), 0, 1'b1);
    end

    // Abort a partial store while it sits in the merge state.
    mem[32'h4000] = 64'h0011223344556677;
    tw        = total_wr;
    req_addr  = 32'h4001;
    req_data  = 64'hEE;
    req_type  = 3'd4;
    req_valid = 1'b1;
    @(negedge clk);
    chk("abort_accept_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_rd_en", 64'(mem_rd_en), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_wr_en", 64'(mem_wr_en), 64'd0);
    chk("abort_rd_en_low", 64'(mem_rd_en), 64'd0);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_resp_err", 64'(resp_err), 64'd0);
    chk("abort_mem_addr", 64'(mem_addr), 64'd0);
    chk("abort_mem_wdata", mem_wdata, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_no_write", 64'(total_wr), 64'(tw));
    chk("abort_mem_kept", mem_rd(32'h4000), 64'h0011223344556677);
    @(posedge clk);
    #1;
    do_store(32'h4002, 64'h99, 3'd4, mk(1'b0, 64'h0011223344996677, 4, 1, 1, 32'h4000), 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
